// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: MDUOp encodings,
// FSM state codes and the behavioural multiply/divide result helpers.
package mult_div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Low 64 bits of the extended product are exact for both signednesses.
  function automatic hilo_t mul_hilo(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic              is_signed);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    ea = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return hilo_t'(ea * eb);
  endfunction

  // Magnitude division keeps INT_MIN / -1 well defined (wraps to INT_MIN).
  function automatic hilo_t div_hilo(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic              is_signed);
    hilo_t             r;
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] rm;
    neg_a = is_signed & a[DATA_W-1];
    neg_b = is_signed & b[DATA_W-1];
    ma    = neg_a ? (~a + DATA_W'(1)) : a;
    mb    = neg_b ? (~b + DATA_W'(1)) : b;
    if (mb == '0) mb = DATA_W'(1);
    q     = ma / mb;
    rm    = ma % mb;
    r.lo  = (neg_a ^ neg_b) ? (~q + DATA_W'(1)) : q;
    r.hi  = neg_a ? (~rm + DATA_W'(1)) : rm;
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers and a
// busy interlock; results commit when the down-counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   MDUOp,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] RD
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_d;
  hilo_t             mul_res;
  hilo_t             div_res;

  assign mul_res = mul_hilo(a_q, b_q, sgn_q);
  assign div_res = div_hilo(a_q, b_q, sgn_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy    <= busy_d;
    end
  end

  // Next-state and datapath update; requests are only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
              a_d     = A;
              b_d     = B;
              sgn_d   = (MDUOp == MDU_MULT);
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              a_d     = A;
              b_d     = B;
              sgn_d   = (MDUOp == MDU_DIV);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = ST_DIV;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = mul_res.hi;
          lo_d    = mul_res.lo;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) begin
          // Divide by zero burns the full latency but leaves HI/LO intact.
          if (b_q != '0) begin
            hi_d = div_res.hi;
            lo_d = div_res.lo;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // HI/LO read port feeds the GRF write-data mux in the same cycle.
  always_comb begin
    RD = '0;
    case (MDUOp)
      MDU_MFHI: RD = hi_q;
      MDU_MFLO: RD = lo_q;
      default:  RD = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;
  int n;

  mult_div_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDUOp(MDUOp),
    .A    (A),
    .B    (B),
    .busy (busy),
    .RD   (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one start strobe; returns at the negedge after the start edge,
  // with operands scrambled so only latched values can matter.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDUOp = MDU_NONE; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    MDUOp = MDU_MFHI; #1;
    check({tag, "_hi"}, RD, exp_hi);
    MDUOp = MDU_MFLO; #1;
    check({tag, "_lo"}, RD, exp_lo);
    MDUOp = MDU_NONE; #1;
    check({tag, "_rd_none"}, RD, 32'h0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    issue(op, a, b);
    count_busy(c);
    check({tag, "_busy_cycles"}, 32'(c), 32'(cycles));
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    read_hilo("rst", 32'h0, 32'h0);
    reset = 1'b0;

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MDU_DIVU,  32'd7,         32'd2, 10, 32'd1, 32'd3);

    issue(MDU_MTHI, 32'h12, 32'h0);
    check("mthi_busy", 32'(busy), 32'h0);
    issue(MDU_MTLO, 32'h34, 32'h0);
    check("mtlo_busy", 32'(busy), 32'h0);
    read_hilo("mt", 32'h12, 32'h34);
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 10, 32'h12, 32'h34);

    // Second start on the 2nd busy cycle must be ignored.
    issue(MDU_MULT, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; MDUOp = MDU_MULT; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0; MDUOp = MDU_NONE;
    count_busy(n);
    check("ign_busy_cycles", 32'(n + 2), 32'd5);
    read_hilo("ign", 32'h0, 32'd12);

    // Reset on the 3rd busy cycle of DIV 100/7.
    issue(MDU_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1 check("async_rst_busy", 32'(busy), 32'h0);
    MDUOp = MDU_MFHI; #1 check("async_rst_hi", RD, 32'h0);
    MDUOp = MDU_MFLO; #1 check("async_rst_lo", RD, 32'h0);
    MDUOp = MDU_NONE;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);
    read_hilo("post_rst", 32'h0, 32'h0);

    // Start accepted on the first edge after reset release.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; MDUOp = MDU_MULT; A = 32'd6; B = 32'd7;
    @(negedge clk);
    start = 1'b0; MDUOp = MDU_NONE;
    check("first_edge_busy", 32'(busy), 32'h1);
    count_busy(n);
    check("first_edge_cycles", 32'(n), 32'd5);
    read_hilo("first_edge", 32'h0, 32'd42);

    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
